// File: rtl/win_checker.sv
// Five-in-a-row detector: walks outward from the placed stone in four directions.
// Optional WIN_EXACT_FIVE_EN: full scan, only an exact count of five wins.
module win_checker #(
  parameter int BOARD_SIZE = 15,
  parameter int COORD_W    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] org_x,
  input  logic [COORD_W-1:0] org_y,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  input  logic [1:0]         rd_data,
  output logic               busy,
  output logic               done,
  output logic               win,
  output logic [1:0]         win_colour
);

`ifdef WIN_EXACT_FIVE_EN
  localparam int L = 5;
`else
  localparam int L = 4;
`endif

  localparam logic signed [COORD_W:0] MAXC =
    (COORD_W+1)'(BOARD_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, WALK_POS, WALK_NEG, FIN
  } state_t;

  state_t state, state_n;

  logic [COORD_W-1:0] ox, oy;
  logic [1:0]         colour;
  logic [1:0]         dir;
  logic [2:0]         k;
  logic [3:0]         count;
  logic [3:0]         count_inc;

  logic signed [COORD_W:0] kk, step, cx, cy;
  logic walking, in_bounds, match, side_end, accept;
  logic five_now;

`ifdef WIN_EXACT_FIVE_EN
  logic [3:0] total;
  assign total = match ? count_inc : count;
`endif

  assign walking   = (state == WALK_POS) || (state == WALK_NEG);
  assign accept    = (state == IDLE) && start && !busy;
  assign count_inc = count + 4'd1;

  // Candidate cell at origin +/- k*d; an overflowed sum lands negative.
  always_comb begin
    kk   = $signed({{(COORD_W-2){1'b0}}, k});
    step = (state == WALK_NEG) ? -kk : kk;
    cx   = $signed({1'b0, ox});
    cy   = $signed({1'b0, oy});
    case (dir)
      2'd0: cx = cx + step;
      2'd1: cy = cy + step;
      2'd2: begin
        cx = cx + step;
        cy = cy + step;
      end
      default: begin
        cx = cx + step;
        cy = cy - step;
      end
    endcase
  end

  assign in_bounds = !cx[COORD_W] && (cx <= MAXC) &&
                     !cy[COORD_W] && (cy <= MAXC);
  assign match     = walking && in_bounds && (rd_data == colour);
  assign side_end  = !match || (k == 3'(L));

`ifdef WIN_EXACT_FIVE_EN
  assign five_now = 1'b0;
`else
  assign five_now = match && (count_inc == 4'd5);
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = LOAD;
      LOAD: begin
        if (rd_data == 2'b00) state_n = FIN;
        else                  state_n = WALK_POS;
      end
      WALK_POS: begin
        if (five_now)      state_n = FIN;
        else if (side_end) state_n = WALK_NEG;
      end
      WALK_NEG: begin
        if (five_now) state_n = FIN;
        else if (side_end)
          state_n = (dir == 2'd3) ? FIN : WALK_POS;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Read address: origin unless a walk candidate is on the board
  always_comb begin
    rd_x = ox;
    rd_y = oy;
    if (walking && in_bounds) begin
      rd_x = cx[COORD_W-1:0];
      rd_y = cy[COORD_W-1:0];
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ox         <= '0;
      oy         <= '0;
      colour     <= 2'b00;
      dir        <= 2'd0;
      k          <= 3'd0;
      count      <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      win        <= 1'b0;
      win_colour <= 2'b00;
    end else begin
      done <= (state == FIN);
      if (done) busy <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ox         <= org_x;
            oy         <= org_y;
            dir        <= 2'd0;
            busy       <= 1'b1;
            win        <= 1'b0;
            win_colour <= 2'b00;
          end
        end
        LOAD: begin
          colour <= rd_data;
          count  <= 4'd1;
          k      <= 3'd1;
        end
        WALK_POS, WALK_NEG: begin
          if (match) begin
            count <= count_inc;
            k     <= k + 3'd1;
          end
          if (five_now) begin
            win        <= 1'b1;
            win_colour <= colour;
          end
          if (side_end) begin
            k <= 3'd1;
            if (state == WALK_NEG) begin
              dir   <= dir + 2'd1;
              count <= 4'd1;
`ifdef WIN_EXACT_FIVE_EN
              if (total == 4'd5) begin
                win        <= 1'b1;
                win_colour <= colour;
              end
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
